// File: rtl/regfile_hazard_ctrl.sv
// Hazard scoreboard and writeback arbiter in front of the register file.
// It stalls decode on RAW/WAW hazards and shares one write port between the ALU and the LSU.
module regfile_hazard_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clock_i,
  input  logic            nreset_i,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rs0_i,
  input  logic [4:0]      issue_rs1_i,
  input  logic [4:0]      issue_rd_i,
  input  logic            issue_rd_we_i,
  output logic            issue_ready_o,
  output logic            du_stall_o,
  output logic            du_r_enable_o,
  input  logic            alu_wb_valid_i,
  input  logic [4:0]      alu_wb_rd_i,
  input  logic [XLEN-1:0] alu_wb_data_i,
  output logic            alu_wb_ready_o,
  input  logic            lsu_wb_valid_i,
  input  logic [4:0]      lsu_wb_rd_i,
  input  logic [XLEN-1:0] lsu_wb_data_i,
  output logic            lsu_wb_ready_o,
  output logic            wbu_w_enable_o,
  output logic [4:0]      rdt_addr_o,
  output logic [XLEN-1:0] wbu_wdata_o,
  output logic [NREG-1:0] busy_o,
  output logic            wb_err_o
);

  typedef enum logic {RR_ALU = 1'b0, RR_LSU = 1'b1} rr_e;

  rr_e             rr_q, rr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            wen_q, wen_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            ready;
  logic            alu_gnt, lsu_gnt;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;

  always_comb begin
    ready = ~busy_q[issue_rs0_i] & ~busy_q[issue_rs1_i] &
            ~(issue_rd_we_i & busy_q[issue_rd_i]);

    alu_gnt = alu_wb_valid_i & (~lsu_wb_valid_i | (rr_q == RR_ALU));
    lsu_gnt = lsu_wb_valid_i & (~alu_wb_valid_i | (rr_q == RR_LSU));

    rr_d = rr_q;
    if (alu_wb_valid_i && lsu_wb_valid_i)
      rr_d = (rr_q == RR_ALU) ? RR_LSU : RR_ALU;

    gnt_rd   = lsu_gnt ? lsu_wb_rd_i   : alu_wb_rd_i;
    gnt_data = lsu_gnt ? lsu_wb_data_i : alu_wb_data_i;

    // A granted write to x0 is consumed without reaching the register file.
    wen_d   = (alu_gnt | lsu_gnt) & (gnt_rd != 5'd0);
    waddr_d = wen_d ? gnt_rd   : waddr_q;
    wdata_d = wen_d ? gnt_data : wdata_q;

    // Clear on commit first so a same-edge set of the same register wins.
    busy_d = busy_q;
    if (wen_q)
      busy_d[waddr_q] = 1'b0;
    if (issue_valid_i && ready && issue_rd_we_i && (issue_rd_i != 5'd0))
      busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rr_q    <= RR_ALU;
      busy_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign issue_ready_o  = ready;
  assign du_stall_o     = issue_valid_i & ~ready;
  assign du_r_enable_o  = issue_valid_i & ready;
  assign alu_wb_ready_o = alu_gnt;
  assign lsu_wb_ready_o = lsu_gnt;
  assign wbu_w_enable_o = wen_q;
  assign rdt_addr_o     = waddr_q;
  assign wbu_wdata_o    = wdata_q;
  assign busy_o         = busy_q;
  // Flags a commit to a register that had no outstanding write.
  assign wb_err_o       = wen_q & ~busy_q[waddr_q];

endmodule

// File: tb/tb_regfile_hazard_ctrl.sv
// Directed testbench for regfile_hazard_ctrl: write-port traffic goes through a scoreboard queue.
module tb_regfile_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs0, issue_rs1, issue_rd;
  logic        issue_we;
  logic        issue_ready, du_stall, du_r_enable;
  logic        alu_v, lsu_v;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;
  logic        wb_err;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  regfile_hazard_ctrl #(.XLEN(32), .NREG(32)) dut (
    .clock_i(clk), .nreset_i(rst_n),
    .issue_valid_i(issue_valid), .issue_rs0_i(issue_rs0), .issue_rs1_i(issue_rs1),
    .issue_rd_i(issue_rd), .issue_rd_we_i(issue_we),
    .issue_ready_o(issue_ready), .du_stall_o(du_stall), .du_r_enable_o(du_r_enable),
    .alu_wb_valid_i(alu_v), .alu_wb_rd_i(alu_rd), .alu_wb_data_i(alu_data),
    .alu_wb_ready_o(alu_ready),
    .lsu_wb_valid_i(lsu_v), .lsu_wb_rd_i(lsu_rd), .lsu_wb_data_i(lsu_data),
    .lsu_wb_ready_o(lsu_ready),
    .wbu_w_enable_o(wen), .rdt_addr_o(waddr), .wbu_wdata_o(wdata),
    .busy_o(busy), .wb_err_o(wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [4:0] rd, input logic we);
    issue_valid = v; issue_rs0 = rs0; issue_rs1 = rs1; issue_rd = rd; issue_we = we;
  endtask

  // Monitor: every committed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wen) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%08h with nothing expected", waddr, wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, waddr}, {27'd0, e.addr});
        check("wr_data", wdata, e.data);
        check("wr_err", {31'd0, wb_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    alu_v = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_v = 1'b0; lsu_rd = '0; lsu_data = '0;
    tick(); tick();
    check("rst_busy", busy, 32'd0);
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_addr", {27'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_err", {31'd0, wb_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Arbitration from reset: ALU first, then LSU; both targets not busy.
    alu_v = 1'b1; alu_rd = 5'd4; alu_data = 32'h11;
    lsu_v = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h22;
    #1;
    check("arb1_alu_rdy", {31'd0, alu_ready}, 32'd1);
    check("arb1_lsu_rdy", {31'd0, lsu_ready}, 32'd0);
    exp_q.push_back('{addr: 5'd4, data: 32'h11, err: 1'b1});
    tick();
    check("arb2_alu_rdy", {31'd0, alu_ready}, 32'd0);
    check("arb2_lsu_rdy", {31'd0, lsu_ready}, 32'd1);
    exp_q.push_back('{addr: 5'd6, data: 32'h22, err: 1'b1});
    tick();
    alu_v = 1'b0; lsu_v = 1'b0;
    tick(); tick();

    // Reset during the grant cycle drops the write and the scoreboard.
    set_issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("rstmid_busy_set", busy, 32'h0000_0020);
    alu_v = 1'b1; alu_rd = 5'd5; alu_data = 32'h55;
    #1;
    check("rstmid_alu_rdy", {31'd0, alu_ready}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 32'd0);
    check("rstmid_wen", {31'd0, wen}, 32'd0);
    alu_v = 1'b0;
    tick();
    check("rstmid_wen_edge", {31'd0, wen}, 32'd0);
    rst_n = 1'b1;
    tick();

    // RAW stall on x3 until the ALU commit retires.
    set_issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
    #1;
    check("raw_first_ren", {31'd0, du_r_enable}, 32'd1);
    tick();
    check("raw_busy3", busy, 32'h0000_0008);
    set_issue(1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
    alu_v = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    check("raw_stall_T", {31'd0, du_stall}, 32'd1);
    check("raw_ren_T", {31'd0, du_r_enable}, 32'd0);
    check("raw_alu_rdy", {31'd0, alu_ready}, 32'd1);
    exp_q.push_back('{addr: 5'd3, data: 32'hDEADBEEF, err: 1'b0});
    tick();
    alu_v = 1'b0;
    #1;
    check("raw_stall_T1", {31'd0, du_stall}, 32'd1);
    check("raw_wen_T1", {31'd0, wen}, 32'd1);
    tick();
    check("raw_ready_T2", {31'd0, issue_ready}, 32'd1);
    check("raw_ren_T2", {31'd0, du_r_enable}, 32'd1);
    check("raw_busy_T2", busy, 32'd0);
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();

    // WAW: writer blocked, non-writer accepted.
    set_issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
    tick();
    check("waw_busy7", busy, 32'h0000_0080);
    #1;
    check("waw_stall", {31'd0, du_stall}, 32'd1);
    issue_we = 1'b0;
    #1;
    check("waw_we0_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("waw_busy_kept", busy, 32'h0000_0080);
    alu_v = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    exp_q.push_back('{addr: 5'd7, data: 32'h77, err: 1'b0});
    tick();
    alu_v = 1'b0;
    tick();
    check("waw_busy_clr", busy, 32'd0);

    // x0 is never busy and writebacks to it are swallowed.
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    #1;
    check("x0_issue_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    set_issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    check("x0_busy", busy, 32'd0);
    lsu_v = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBAD0;
    #1;
    check("x0_lsu_rdy", {31'd0, lsu_ready}, 32'd1);
    tick();
    lsu_v = 1'b0;
    check("x0_wen", {31'd0, wen}, 32'd0);
    check("x0_err", {31'd0, wb_err}, 32'd0);
    tick();

    // Spurious writeback to x9: written, error pulse for one cycle.
    alu_v = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    exp_q.push_back('{addr: 5'd9, data: 32'h99, err: 1'b1});
    tick();
    alu_v = 1'b0;
    tick();
    check("spur_err_gone", {31'd0, wb_err}, 32'd0);
    check("spur_busy", busy, 32'd0);

    tick(); tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule

// File: doc/regfile_hazard_ctrl.md
Name: regfile_hazard_ctrl

Overview:
Sequencing controller in front of register_file. It keeps a per-register scoreboard of outstanding writes and stalls decode on RAW/WAW hazards. It drives the register file read enable and shares the single register file write port between the ALU and LSU writeback requesters using round-robin arbitration. Sits between decode, the execute/LSU writeback paths and register_file.

Parameters:
XLEN, 32, data width of the register file.
NREG, 32, number of architectural registers; fixed at 32 (5-bit index).

Ports:
clock_i  in  1  system clock, rising edge.
nreset_i  in  1  asynchronous active-low reset.
issue_valid_i  in  1  decode presents an instruction.
issue_rs0_i  in  5  source register 0 index.
issue_rs1_i  in  5  source register 1 index.
issue_rd_i  in  5  destination register index.
issue_rd_we_i  in  1  instruction writes rd.
issue_ready_o  out  1  instruction accepted this cycle (hazard-free).
du_stall_o  out  1  decode stall = issue_valid_i & ~issue_ready_o.
du_r_enable_o  out  1  register file read enable = issue_valid_i & issue_ready_o.
alu_wb_valid_i  in  1  ALU writeback request.
alu_wb_rd_i  in  5  ALU destination.
alu_wb_data_i  in  XLEN  ALU result.
alu_wb_ready_o  out  1  ALU request granted this cycle.
lsu_wb_valid_i  in  1  LSU writeback request.
lsu_wb_rd_i  in  5  LSU destination.
lsu_wb_data_i  in  XLEN  LSU load data.
lsu_wb_ready_o  out  1  LSU request granted this cycle.
wbu_w_enable_o  out  1  register file write enable (registered).
rdt_addr_o  out  5  register file write address (registered).
wbu_wdata_o  out  XLEN  register file write data (registered).
busy_o  out  32  scoreboard: bit n = write to xn outstanding.
wb_err_o  out  1  one-cycle pulse: writeback to a non-busy, non-zero register.

Behaviour:
- Reset (async, nreset_i low): busy = 0, wbu_w_enable_o = 0, rdt_addr_o = 0, wbu_wdata_o = 0, wb_err_o = 0, RR pointer = ALU. Reset takes effect immediately and drops any in-flight write.
- busy[0] is hardwired to 0.
- Issue is combinational: issue_ready_o = ~busy[rs0] & ~busy[rs1] & ~(issue_rd_we_i & busy[rd]). Ready does not depend on issue_valid_i.
- On an accepted issue with issue_rd_we_i = 1 and rd != 0, busy[rd] is set at the next edge.
- Register file read data is valid in the cycle after du_r_enable_o.
- Arbitration: at most one grant per cycle. ready is combinational from valid and the RR pointer.
  - Single requester: that requester is granted.
  - Both requesters: the one the pointer favours is granted, and the pointer then moves to the other.
  - The pointer updates only on a grant when both requesters are valid.
- A requester holds valid, rd and data stable until granted.
- Granted write with rd != 0: at the next edge wbu_w_enable_o = 1 and rdt_addr_o / wbu_wdata_o take the granted rd and data. Otherwise wbu_w_enable_o = 0 at that edge.
- Granted write with rd == 0: consumed and dropped; no write is emitted and wb_err_o is not raised.
- busy[rd] clears on the edge where wbu_w_enable_o = 1, i.e. when register_file commits. Total latency is grant cycle, then write cycle, then a dependent issue is accepted in the following cycle. This guarantees a dependent read samples the register only after it is written.
- Same-edge set and clear of one register cannot occur, because WAW blocks the issue. If it does occur, set wins.
- wb_err_o pulses in the write cycle when the committed rd was not busy. The write is still performed.
- Back-to-back grants give a continuous wbu_w_enable_o stream, one write per cycle.

Test Plan:
- Reset mid-write: alu_wb to x5 granted, nreset_i low before the next edge -> wbu_w_enable_o = 0 and busy_o = 0 immediately; no write emitted.
- RAW stall: issue rd=x3 we=1 accepted; next cycle issue rs0=x3 -> du_stall_o = 1. ALU writes x3 = 0xDEADBEEF: granted cycle T, wbu_w_enable_o = 1 / rdt_addr_o = 3 in T+1, busy[3] clears at end of T+1, issue accepted T+2 with du_r_enable_o = 1.
- WAW: x7 busy, issue rd=x7 we=1 -> stalled. Same issue with we=0 and sources x1/x2 -> accepted, busy unchanged.
- Arbitration: ALU (x4, 0x11) and LSU (x6, 0x22) valid for 2 cycles from reset -> ALU granted first, LSU second; writes x4=0x11 then x6=0x22 on consecutive cycles.
- x0 handling: issue rd=x0 we=1 -> busy_o stays 0. LSU writeback to x0 -> lsu_wb_ready_o = 1, wbu_w_enable_o stays 0, wb_err_o = 0.
- Spurious writeback: ALU writes x9 with busy[9] = 0 -> x9 written and wb_err_o pulses for one cycle.
